// File: rtl/rr_arb_mux.sv
// N-to-1 registered multiplexer with valid/ready handshakes and a built-in
// round-robin (ARB_MODE=0) or fixed-priority (ARB_MODE=1) arbiter.
module rr_arb_mux #(
   parameter int NUM_IN     = 4,
   parameter int DATA_WIDTH = 32,
   parameter int SEL_WIDTH  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
   parameter int ARB_MODE   = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_IN-1:0]            in_valid,
   input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
   output logic [NUM_IN-1:0]            in_ready,
   output logic                         out_valid,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [SEL_WIDTH-1:0]         out_sel,
   input  logic                         out_ready
);

   logic                  load_en;
   logic [SEL_WIDTH-1:0]  ptr;
   logic [SEL_WIDTH-1:0]  win_idx;
   logic                  win_found;
   logic [DATA_WIDTH-1:0] win_data;

   assign load_en = !out_valid || out_ready;

   // Loops run from the least preferred candidate to the most preferred so the
   // last matching write is the winner; the round-robin wrap is a subtract, not a mask.
   always_comb begin
      int cand;
      win_idx   = '0;
      win_found = 1'b0;
      cand      = 0;
      if (ARB_MODE == 1) begin
         for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
               win_idx   = SEL_WIDTH'(i);
               win_found = 1'b1;
            end
         end
      end else begin
         for (int off = NUM_IN; off >= 1; off--) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_IN) begin
               cand = cand - NUM_IN;
            end
            if (in_valid[cand]) begin
               win_idx   = SEL_WIDTH'(cand);
               win_found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      win_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (win_idx == SEL_WIDTH'(i)) begin
            win_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            in_ready[i] = load_en && win_found;
         end
      end
   end

   // Pointer starts at NUM_IN-1 so channel 0 is preferred on the first grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= SEL_WIDTH'(NUM_IN - 1);
      end else if (load_en) begin
         if (win_found) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_sel   <= win_idx;
            ptr       <= win_idx;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
